// File: rtl/rnn_pkg.sv
// Shared types and helpers for the RNN accelerator datapath.
package rnn_pkg;

  localparam int FX_DW   = 16;
  localparam int FX_COLS = 32;

  typedef logic signed [FX_DW-1:0] fx_t;
  typedef logic signed [2*FX_DW+$clog2(FX_COLS)-1:0] acc_t;

  typedef enum logic [1:0] {IDLE, RUN, WB, DONE} mv_state_t;

  // Clamp a wide signed value into the dw-bit signed range; caller truncates.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int dw);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/matvec_engine_mac_lane.sv
// One MAC lane: signed multiplier feeding a wide accumulator.
module mac_lane #(
  parameter int DW = 16,
  parameter int AW = 37
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] w,
  input  logic signed [DW-1:0] x,
  output logic signed [AW-1:0] acc
);

  logic signed [2*DW-1:0] prod;

  assign prod = w * x;

  // Accumulate one product per enabled cycle; clear has priority.
  always_ff @(posedge clk) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + AW'(prod);
  end

endmodule

// File: rtl/matvec_engine.sv
// Sequential y = W*x (or y += W*x) engine with LANES rows computed in parallel.
module matvec_engine
  import rnn_pkg::*;
#(
  parameter int ROWS  = 32,
  parameter int COLS  = 32,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int LANES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_we,
  input  logic [$clog2(ROWS)-1:0] w_row,
  input  logic [$clog2(COLS)-1:0] w_col,
  input  logic [DW-1:0]           w_data,
  input  logic                    x_we,
  input  logic [$clog2(COLS)-1:0] x_idx,
  input  logic [DW-1:0]           x_data,
  input  logic                    start,
  input  logic                    acc,
  input  logic                    y_clr,
  input  logic [$clog2(ROWS)-1:0] y_idx,
  output logic [DW-1:0]           y_data,
  output logic                    busy,
  output logic                    ready
);

  localparam int GROUPS = ROWS / LANES;
  localparam int RW     = $clog2(ROWS);
  localparam int CW     = $clog2(COLS);
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int DEPTH  = GROUPS * COLS;
  localparam int DAW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW     = 2 * DW + CW;

  generate
    if ((ROWS % LANES) != 0) begin : g_bad_lanes
      $error("matvec_engine: ROWS must be a multiple of LANES");
    end
  endgenerate

  mv_state_t         state;
  logic [GW-1:0]     g;
  logic [CW-1:0]     c;
  logic              acc_mode;

  logic              wr_open, go, lane_clr, lane_en, w_ok;
  logic [DAW-1:0]    rd_addr, w_addr;
  logic signed [DW-1:0] x_cur;
  logic [LANES-1:0][DW-1:0] y_new;

  logic signed [DW-1:0] xmem [COLS];
  logic signed [DW-1:0] y    [ROWS];

  assign wr_open  = (state == IDLE) || (state == DONE);
  assign go       = (state == IDLE) && start;
  assign lane_clr = go || (state == WB);
  assign lane_en  = (state == RUN);
  assign rd_addr  = DAW'(int'(g) * COLS + int'(c));
  assign w_ok     = w_we && wr_open && (int'(w_row) < ROWS) && (int'(w_col) < COLS);
  assign w_addr   = DAW'((int'(w_row) / LANES) * COLS + int'(w_col));
  assign x_cur    = xmem[c];

  // Input vector store, written only while the engine is not busy.
  always_ff @(posedge clk) begin
    if (x_we && wr_open && (int'(x_idx) < COLS)) xmem[x_idx] <= x_data;
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [DW-1:0] bank [DEPTH];
      logic signed [DW-1:0] w_rd, y_old;
      logic signed [AW-1:0] lacc;
      logic signed [AW:0]   shf, addend, sum;
      logic [RW-1:0]        row_l;

      // Weight bank for rows r with r % LANES == l, addressed by (group, column).
      always_ff @(posedge clk) begin
        if (w_ok && ((int'(w_row) % LANES) == l)) bank[w_addr] <= w_data;
      end

      assign w_rd = bank[rd_addr];

      mac_lane #(.DW(DW), .AW(AW)) u_mac (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (lane_clr),
        .en   (lane_en),
        .w    (w_rd),
        .x    (x_cur),
        .acc  (lacc)
      );

      // Write-back value: floor-rescale, optional add of old y, saturate.
      assign row_l    = RW'(int'(g) * LANES + l);
      assign y_old    = y[row_l];
      assign shf      = (AW+1)'(lacc >>> FRAC);
      assign addend   = acc_mode ? (AW+1)'(y_old) : '0;
      assign sum      = shf + addend;
      assign y_new[l] = DW'(saturate(64'(sum), DW));
    end
  endgenerate

  // Result registers: written per group in WB, clearable only in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) y[i] <= '0;
    end else if (state == WB) begin
      for (int l = 0; l < LANES; l++) y[RW'(int'(g) * LANES + l)] <= y_new[l];
    end else if ((state == IDLE) && y_clr && !start) begin
      for (int i = 0; i < ROWS; i++) y[i] <= '0;
    end
  end

  // Registered result read port, no bypass of same-cycle write-back.
  always_ff @(posedge clk) begin
    if (!rst_n) y_data <= '0;
    else        y_data <= (int'(y_idx) < ROWS) ? y[y_idx] : '0;
  end

  // Control FSM: one RUN cycle per column, one WB per lane group.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      g        <= '0;
      c        <= '0;
      acc_mode <= 1'b0;
      busy     <= 1'b0;
      ready    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (start) begin
            acc_mode <= acc;
            g        <= '0;
            c        <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (c == CW'(COLS - 1)) state <= WB;
          else                    c     <= c + 1'b1;
        end
        WB: begin
          c <= '0;
          if (g == GW'(GROUPS - 1)) begin
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= DONE;
          end else begin
            g     <= g + 1'b1;
            state <= RUN;
          end
        end
        DONE: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/matvec_engine.md
# matvec_engine

Parametrised sequential matrix-vector multiply-accumulate engine for the RNN accelerator. It replaces the fixed-size weight and recurrent multipliers with one block generic in rows, columns, word width, fraction bits and parallel MAC lanes. It adds an accumulate mode so W·x + R·h + b is built in place. It also adds saturation and an explicit result-clear. The top-level Avalon register decoder drives its load, start and read ports.

## Interface
- ROWS, 32, output vector length (matrix rows)
- COLS, 32, input vector length (matrix columns)
- DW, 16, signed fixed-point word width
- FRAC, 8, fraction bits (Q(DW-FRAC).FRAC)
- LANES, 4, parallel MAC lanes; ROWS % LANES must be 0 (elaboration error otherwise)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- w_we  in  1  weight write strobe
- w_row  in  $clog2(ROWS)  weight row index
- w_col  in  $clog2(COLS)  weight column index
- w_data  in  DW  weight value
- x_we  in  1  input vector write strobe
- x_idx  in  $clog2(COLS)  input element index
- x_data  in  DW  input element
- start  in  1  begin multiply (level sampled in IDLE)
- acc  in  1  sampled with start: 1 = add to existing y, 0 = overwrite
- y_clr  in  1  zero all results (IDLE only)
- y_idx  in  $clog2(ROWS)  result read index
- y_data  out  DW  result read data, registered
- busy  out  1  high in RUN/WB
- ready  out  1  one-cycle completion pulse

## Operation
- State machine: IDLE, RUN, WB, DONE.
- IDLE:
  - start=1 → latch acc, clear lane accumulators, set group g=0, column c=0, go to RUN.
  - y_clr=1 (without start) → all y[*]=0.
  - start and y_clr together → start wins; y_clr is ignored.
- RUN, one cycle per column: lane l adds W[g·LANES+l][c]·x[c] to its accumulator. When c=COLS-1, go to WB.
- WB, one cycle: for each lane, r = g·LANES+l.
  - s = acc_l >>> FRAC (arithmetic shift, floor).
  - If the latched acc=1, add y[r].
  - Saturate to DW signed, i.e. [-2^(DW-1), 2^(DW-1)-1], and write y[r].
  - Clear accumulators, c=0. If g = ROWS/LANES-1 go to DONE, else g+1 and return to RUN.
- DONE, one cycle: ready=1, then IDLE.
- Widths:
  - Product is 2·DW.
  - Accumulator is 2·DW+$clog2(COLS) and never overflows.
  - The acc-mode add is done at accumulator width before saturation.
- Writes:
  - w_we/x_we are accepted in IDLE and DONE.
  - They are dropped while busy=1.
  - Out-of-range indices are ignored.
- start while busy → ignored (not queued). y_clr while busy → ignored.
- Reset:
  - State→IDLE; busy=0, ready=0, y[*]=0, y_data=0, counters and accumulators 0.
  - Weight and x storage are not reset (RAM-inferable).
  - Reset mid-RUN aborts with no partial y written.

## Timing
- start sampled high in IDLE at edge 0 → busy=1 from edge 1.
- ready high for exactly one cycle after edge (ROWS/LANES)·(COLS+1)+1.
- busy falls with ready rising.
- Example: ROWS=COLS=32, LANES=4 gives 265 cycles.
- y_data = y[y_idx] one cycle after y_idx is presented. A WB write to the addressed row is visible on the following read cycle (no bypass).
- W/x write latency 1 cycle: a write at edge n is used by a start sampled at edge n+1.

## Structure
- Shared package rnn_pkg:
  - fixed-point typedef fx_t (logic signed [DW-1:0])
  - accumulator typedef
  - mv_state_t enum {IDLE, RUN, WB, DONE}
  - saturate function (acc width → DW)
- Sub-module mac_lane: one multiplier plus accumulator, with clear and enable. It is instantiated LANES times via generate.
- Weight store: per-lane banks, rows r with r % LANES == l, each bank (ROWS/LANES)·COLS×DW, so every lane reads one word per cycle.

## Test plan
All cases use ROWS=4, COLS=4, LANES=2, DW=16, FRAC=8.
- Overwrite mode: W=identity (0x0100 diagonal), x={0x0100,0x0200,0xFF00,0x0000}, acc=0 → y={0x0100,0x0200,0xFF00,0x0000}; ready exactly 11 cycles after start, busy high 10 cycles.
- Accumulate mode: repeat the previous case with acc=1 → y={0x0200,0x0400,0xFE00,0x0000}.
- Saturation and rounding:
  - W all 0x7FFF, x all 0x7FFF → y all 0x7FFF.
  - x all 0x8000 → y all 0x8000.
  - W[0][0]=0x0080, x[0]=0xFFFF, rest 0 → y[0]=0xFFFF (floor).
- Busy protection: start pulse and w_we (W[0][0]=0x7FFF) during RUN → no restart, only one ready pulse, W unchanged, result matches the first test.
- Reset mid-run: rst_n low for 1 cycle during RUN (group 1) → busy=0, ready never pulses, all y read 0; a new start yields correct results.
- Clear: y_clr in IDLE after the first test → all y=0. y_clr during RUN → ignored, results written normally.
